system_processor_top: RTL and testbench
=======================================

# system_processor_top

Top-level processor for the vehicle's motor/encoder I/O. Each clock it decodes a 12-bit command word to set the duty cycle of four 8-bit PWM outputs or to select an 8-bit readout on `dataout`. The readout is encoder period/direction, a fixed test pattern, or zero. It measures four quadrature encoders (A/B channel pairs) and sits between the host command interface and the motor drivers.

## Interface
Parameters:
- `PRESCALE_SHIFT`, default 3: the encoder period is reported in units of 2^PRESCALE_SHIFT clocks.
- `TEST_PATTERN`, default 8'hAA: the value returned by the test opcode.

Ports:
- `clk_sys` input, 1 bit: the single system clock (nominal 31.25 MHz). One clock; reset is synchronous and active-low.
- `rst_n` input, 1 bit: synchronous, active-low reset.
- `A` input, 4 bits: encoder channel A; bit n belongs to encoder n+1. Asynchronous to the clock.
- `B` input, 4 bits: encoder channel B, same bit mapping. Asynchronous to the clock.
- `cmdata` input, 12 bits: command. `[11:8]` is the opcode, `[7:0]` is the argument.
- `dataout` output, 8 bits: readout register.
- `pwm1`, `pwm2`, `pwm3`, `pwm4` output, 1 bit each: PWM channels 1-4.

## Operation
- `cmdata` is registered into `cmd_q` every clock. All decoding uses `cmd_q`.
- Opcodes:
  - 0x9, 0xA, 0xB, 0xC: write `duty1`..`duty4` = `cmd_q[7:0]`. `dataout` is cleared to 0.
  - 0x1..0x4: `dataout` = measurement of encoder 1..4. The argument bits are ignored.
  - 0xF: `dataout` = TEST_PATTERN.
  - 0x0, 0x5-0x8, 0xD, 0xE: `dataout` = 0. No state change.
- A duty register holds its value until the same opcode is written again. Holding a write opcode rewrites the same value every cycle, which is harmless.
- PWM:
  - One shared 8-bit free-running counter `pcnt` wraps 255→0, giving a period of 256 clocks.
  - `pwmN` is registered as (`pcnt` < `dutyN`).
  - Duty 0 gives a constant low output. Duty 255 gives high for 255 of every 256 clocks.
  - A duty change applies from the next compare, with no period alignment.
- Encoder measurement, per encoder n:
  - A[n] and B[n] each pass through a 2-flop synchronizer. A rising edge of synced A is detected against a delayed copy.
  - A 16-bit clock counter `ccnt` increments every clock and saturates at 0xFFFF.
  - On each A rising edge:
    - Latch `period` = min(`ccnt` >> PRESCALE_SHIFT, 127).
    - Latch `dir` = synced B[n].
    - Reset `ccnt` to 1.
  - The first rising edge after reset only resets `ccnt`. `period` stays 0 until a second edge arrives.
  - If `ccnt` saturates (stall), `period` is forced to 127 and `dir` is held.
  - The measurement byte is {`dir`, `period[6:0]`}.
- Reset values: `cmd_q`, the duty registers, `pcnt`, `ccnt`, measurements, synchronizers and `dataout` are all 0. `pwm1`-`pwm4` are 0.

## Timing
- A change on `cmdata` appears on `dataout` 2 clocks later (register `cmd_q`, then register `dataout`).
- A duty write takes effect in `duty` 2 clocks after `cmdata` changes. The matching `pwm` output can reflect it 1 clock after that.
- Latency from an A edge to the measurement update: 3 clocks (2 synchronizer stages + 1 edge detect). This latency cancels out of the period.
- Synchronous reset asserted mid-operation: every register returns to its reset value on the next clock edge. Any measurement in progress is discarded.
- A and B changing in the same clock is legal. Direction is sampled from synced B on the same clock as the detected A rise, so it is the post-change B value.

## Structure
- Shared package `sys_proc_pkg`:
  - Opcode constants: `OP_NOP`=0, `OP_ENC1..4`=1..4, `OP_PWM1..4`=9..C, `OP_TEST`=F.
  - `TEST_PATTERN`, `PERIOD_MAX`=127, the command field widths.
- Sub-module `encoder_period_meter`, instantiated 4 times: synchronizer, edge detect, counter, and the latched {`dir`, `period`} output.
- The top level contains the command register, the duty registers, the PWM counter/comparators and the readout mux.
- Expected size: about 150-250 lines total.

## Test plan
- Reset: hold `rst_n`=0 for 30 clocks. Then `dataout`=0x00, all `pwm`=0, and every `pwm` stays 0 for 256 clocks after release while duty is 0.
- PWM duty: send `cmdata`=0x9FF, 0xAF0, 0xB0F, 0xC03, 1000 ns each. Required high counts per 256 clocks: `pwm1`=255, `pwm2`=240, `pwm3`=15, `pwm4`=3. Each duty holds after the opcode changes.
- Test opcode: `cmdata`=0xFFF gives `dataout`=0xAA two clocks later. `cmdata`=0x000 then gives 0x00.
- Encoder period: 32 ns clock, A=B inverted every 2000 ns (period 125 clocks), `cmdata`=0x10F. After 2 A periods `dataout`=0x0F (period 125>>3=15, dir=0 because B falls as A rises).
- Direction and stall: drive A[1] rising while B[1]=1 with a period of 400 clocks, `cmdata`=0x200. Expect `dataout`=0xB2 (dir=1, period 50). Then stop toggling for 65535+ clocks: expect 0xFF.
- Reset mid-operation: assert `rst_n`=0 for 1 clock during PWM and measurement. All outputs and the duties are 0 on the next edge, and the first encoder read afterwards is 0x00 until two A edges have been seen.

Source files
------------

// File: rtl/sys_proc_pkg.sv
// sys_proc_pkg: opcodes, field widths and shared constants for the motor/encoder I/O processor
package sys_proc_pkg;
    localparam int CMD_W    = 12;
    localparam int OPCODE_W = 4;
    localparam int ARG_W    = 8;
    localparam logic [7:0] TEST_PATTERN = 8'hAA;
    localparam logic [6:0] PERIOD_MAX   = 7'd127;
    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP  = 4'h0,
        OP_ENC1 = 4'h1,
        OP_ENC2 = 4'h2,
        OP_ENC3 = 4'h3,
        OP_ENC4 = 4'h4,
        OP_PWM1 = 4'h9,
        OP_PWM2 = 4'hA,
        OP_PWM3 = 4'hB,
        OP_PWM4 = 4'hC,
        OP_TEST = 4'hF
    } opcode_t;
    function automatic logic [6:0] clamp_period(input logic [15:0] v);
        return (v > {9'd0, PERIOD_MAX}) ? PERIOD_MAX : v[6:0];
    endfunction
endpackage

// File: rtl/system_processor_encoder_period_meter.sv
// encoder_period_meter: measures one quadrature encoder's A-rise period and direction
// Ports: i_clk, i_rst_n (sync, active-low), i_a/i_b async encoder channels,
//        o_meas = {dir, period[6:0]} with period in 2^PRESCALE_SHIFT clock units.
module encoder_period_meter
    import sys_proc_pkg::*;
#(
    parameter int PRESCALE_SHIFT = 3
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_a,
    input  logic       i_b,
    output logic [7:0] o_meas
);
    logic [1:0]  r_a_sync;
    logic [1:0]  r_b_sync;
    logic        r_a_dly;
    logic        r_seen;
    logic        r_dir;
    logic [15:0] r_ccnt;
    logic [6:0]  r_period;
    logic        w_rise;
    assign w_rise = r_a_sync[1] & ~r_a_dly;
    assign o_meas = {r_dir, r_period};
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_a_sync <= '0;
            r_b_sync <= '0;
            r_a_dly  <= 1'b0;
            r_seen   <= 1'b0;
            r_dir    <= 1'b0;
            r_ccnt   <= '0;
            r_period <= '0;
        end else begin
            r_a_sync <= {r_a_sync[0], i_a};
            r_b_sync <= {r_b_sync[0], i_b};
            r_a_dly  <= r_a_sync[1];
            if (w_rise) begin
                // the first rise after reset only starts the interval
                r_ccnt <= 16'd1;
                r_seen <= 1'b1;
                if (r_seen) begin
                    r_period <= clamp_period(r_ccnt >> PRESCALE_SHIFT);
                    r_dir    <= r_b_sync[1];
                end
            end else if (r_ccnt != 16'hFFFF) begin
                r_ccnt <= r_ccnt + 16'd1;
            end else begin
                // stalled encoder: report maximum period, keep last direction
                r_period <= PERIOD_MAX;
            end
        end
    end
endmodule

// File: rtl/system_processor_top.sv
// system_processor_top: command decoder, four PWM channels and four encoder readouts
// Ports: clk_sys, rst_n (sync, active-low), A/B encoder channels (bit n = encoder n+1),
//        cmdata {opcode[11:8], arg[7:0]}, dataout readout register, pwm1..pwm4 outputs.
module system_processor_top #(
    parameter int         PRESCALE_SHIFT = 3,
    parameter logic [7:0] TEST_PATTERN   = sys_proc_pkg::TEST_PATTERN
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic [3:0]  A,
    input  logic [3:0]  B,
    input  logic [11:0] cmdata,
    output logic [7:0]  dataout,
    output logic        pwm1,
    output logic        pwm2,
    output logic        pwm3,
    output logic        pwm4
);
    import sys_proc_pkg::*;
    logic [CMD_W-1:0]    r_cmd;
    logic [7:0]          r_duty [4];
    logic [7:0]          r_pcnt;
    logic [3:0]          r_pwm;
    logic [7:0]          r_dataout;
    logic [OPCODE_W-1:0] w_op;
    logic [ARG_W-1:0]    w_arg;
    logic [7:0]          w_meas [4];
    logic [1:0]          w_enc_idx;
    logic                w_is_enc;
    logic [7:0]          w_readout;
    assign w_op      = r_cmd[11:8];
    assign w_arg     = r_cmd[7:0];
    // opcodes 1..4 map onto meter 0..3 (4 wraps to 3 in two bits)
    assign w_enc_idx = w_op[1:0] - 2'd1;
    assign w_is_enc  = (w_op >= OP_ENC1) && (w_op <= OP_ENC4);
    assign w_readout = w_is_enc ? w_meas[w_enc_idx] : (w_op == OP_TEST) ? TEST_PATTERN : 8'h00;
    assign dataout   = r_dataout;
    assign {pwm4, pwm3, pwm2, pwm1} = r_pwm;
    for (genvar g = 0; g < 4; g++) begin : g_enc
        encoder_period_meter #(.PRESCALE_SHIFT(PRESCALE_SHIFT)) u_meter (
            .i_clk   (clk_sys),
            .i_rst_n (rst_n),
            .i_a     (A[g]),
            .i_b     (B[g]),
            .o_meas  (w_meas[g])
        );
    end
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_cmd     <= '0;
            r_pcnt    <= '0;
            r_pwm     <= '0;
            r_dataout <= '0;
            for (int i = 0; i < 4; i++) r_duty[i] <= '0;
        end else begin
            r_cmd     <= cmdata;
            r_pcnt    <= r_pcnt + 8'd1;
            r_dataout <= w_readout;
            for (int i = 0; i < 4; i++) r_pwm[i] <= r_pcnt < r_duty[i];
            case (w_op)
                OP_PWM1: r_duty[0] <= w_arg;
                OP_PWM2: r_duty[1] <= w_arg;
                OP_PWM3: r_duty[2] <= w_arg;
                OP_PWM4: r_duty[3] <= w_arg;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_system_processor_top.sv
// tb_system_processor_top: directed self-checking bench for system_processor_top
module tb_system_processor_top;
    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic [3:0]  A;
    logic [3:0]  B;
    logic [11:0] cmdata;
    logic [7:0]  dataout;
    logic        pwm1, pwm2, pwm3, pwm4;
    int n_checks = 0;
    int n_fail   = 0;
    int c1, c2, c3, c4;

    system_processor_top dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
        .cmdata  (cmdata),
        .dataout (dataout),
        .pwm1    (pwm1),
        .pwm2    (pwm2),
        .pwm3    (pwm3),
        .pwm4    (pwm4)
    );

    always #16 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic count_pwm();
        c1 = 0; c2 = 0; c3 = 0; c4 = 0;
        repeat (256) begin
            @(negedge clk_sys);
            c1 += int'(pwm1);
            c2 += int'(pwm2);
            c3 += int'(pwm3);
            c4 += int'(pwm4);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    initial begin
        rst_n  = 1'b0;
        A      = 4'h0;
        B      = 4'h0;
        cmdata = 12'h000;
        repeat (30) @(posedge clk_sys);
        @(negedge clk_sys);
        check("reset_dataout", 32'(dataout), 32'h00);
        check("reset_pwm", 32'({pwm4, pwm3, pwm2, pwm1}), 32'h0);
        rst_n = 1'b1;
        count_pwm();
        check("idle_pwm_highs", 32'(c1 + c2 + c3 + c4), 32'd0);

        cmdata = 12'h9FF; ticks(32);
        cmdata = 12'hAF0; ticks(32);
        cmdata = 12'hB0F; ticks(32);
        cmdata = 12'hC03; ticks(32);
        check("write_dataout_zero", 32'(dataout), 32'h00);
        cmdata = 12'h000; ticks(4);
        count_pwm();
        check("pwm1_ff", 32'(c1), 32'd255);
        check("pwm2_f0", 32'(c2), 32'd240);
        check("pwm3_0f", 32'(c3), 32'd15);
        check("pwm4_03", 32'(c4), 32'd3);

        cmdata = 12'hFFF; ticks(1);
        check("test_latency_1clk", 32'(dataout), 32'h00);
        ticks(1);
        check("test_pattern", 32'(dataout), 32'hAA);
        cmdata = 12'h000; ticks(2);
        check("nop_clears", 32'(dataout), 32'h00);

        // encoder 1: A and B inverted, toggled every 2000 ns (rise every 125 clocks)
        cmdata = 12'h10F;
        B[0] = 1'b1;
        #5;
        for (int k = 0; k < 6; k++) begin
            #2000;
            A[0] = ~A[0];
            B[0] = ~A[0];
            if (k == 0) begin
                #500;
                check("enc_first_edge_only", 32'(dataout), 32'h00);
                #1500;
                A[0] = ~A[0];
                B[0] = ~A[0];
                k++;
            end
        end
        #300;
        @(negedge clk_sys);
        check("enc1_period", 32'(dataout), 32'h0F);

        // encoder 2: rises 400 clocks apart with B high
        cmdata = 12'h200;
        B[1] = 1'b1;
        A[1] = 1'b1; ticks(200);
        A[1] = 1'b0; ticks(200);
        A[1] = 1'b1; ticks(10);
        check("enc2_dir_period", 32'(dataout), 32'hB2);
        ticks(65600);
        check("enc2_stall", 32'(dataout), 32'hFF);
        cmdata = 12'h100; ticks(3);
        check("enc1_stall_dir0", 32'(dataout), 32'h7F);

        // mid-operation reset with duty 1 active and encoder 1 selected
        cmdata = 12'h9FF; ticks(4);
        cmdata = 12'h100; ticks(300);
        check("pwm1_before_reset", 32'(pwm1), 32'h1);
        rst_n = 1'b0;
        @(posedge clk_sys);
        #1;
        check("midreset_dataout", 32'(dataout), 32'h00);
        check("midreset_pwm", 32'({pwm4, pwm3, pwm2, pwm1}), 32'h0);
        @(negedge clk_sys);
        rst_n = 1'b1;
        count_pwm();
        check("midreset_duties", 32'(c1 + c2 + c3 + c4), 32'd0);
        B[0] = 1'b0;
        A[0] = 1'b0; ticks(5);
        A[0] = 1'b1; ticks(50);
        check("post_reset_one_edge", 32'(dataout), 32'h00);
        A[0] = 1'b0; ticks(150);
        A[0] = 1'b1; ticks(10);
        check("post_reset_period", 32'(dataout), 32'h19);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
